mem_seq: RTL and testbench
==========================

MEM_SEQ -- requirements
Module: mem_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clk and reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 Instruction  input  9  current instruction, decoded as definitions::op_code.
REQ-005 stall  input  1  when high, holds all pointers and FSM state.
REQ-006 pc  input  17  current program counter; captured on frame save request.
REQ-007 frame_save  input  1  single-cycle request to push a 3-byte return frame.
REQ-008 frame_ret  input  1  single-cycle request to pop a 3-byte return frame.
REQ-009 read_data  input  8  data memory read result; asynchronous read, valid in the same cycle as memAddress.
REQ-010 memAddress  output  8  data memory address for the current cycle.
REQ-011 override  output  1  forces the downstream memory controller into sequencer control.
REQ-012 force_write  output  1  write enable used while override is high.
REQ-013 frame_byte  output  8  byte to write during a save; routed to the reg_value path.
REQ-014 busy  output  1  high in any FSM state other than IDLE.
REQ-015 ret_pc  output  17  restored program counter.
REQ-016 ret_valid  output  1  one-cycle pulse when ret_pc is complete.
REQ-017 stk_err  output  1  sticky stack underflow flag.

Function
REQ-018 Registers SHALL be: head (8b data pointer), sp (8b stack pointer, value 0 = empty, stack grows down), FSM state, pc_lat (17b), and ret_pc.
REQ-019 In IDLE, memAddress SHALL be combinational:
  - PSH: sp-1
  - POP: sp
  - all other ops: head
REQ-020 In IDLE, override, force_write and frame_byte SHALL all be 0.
REQ-021 Pointer updates in IDLE SHALL occur only with stall=0 and no frame request:
  - PSH: sp-1
  - POP: sp+1
  - MVL: head-1
  - MVR: head+1
  - all other ops: no change
REQ-022 All pointer arithmetic SHALL be modulo 256 (0x00-1=0xFF, 0xFF+1=0x00).
REQ-023 A POP or frame-load read with sp==0x00 SHALL set stk_err; stk_err SHALL stay set until reset, and sp SHALL still update.
REQ-024 FSM states SHALL be IDLE, SAVE_LO, SAVE_MID, SAVE_HI, LOAD_HI, LOAD_MID, LOAD_LO.
REQ-025 IDLE with frame_save=1 and stall=0 SHALL:
  - latch pc into pc_lat;
  - go to SAVE_LO;
  - suppress any instruction pointer update in that cycle.
REQ-026 IDLE with frame_ret=1, frame_save=0 and stall=0 SHALL go to LOAD_HI.
REQ-027 If frame_save and frame_ret are both high, frame_save SHALL win.
REQ-028 Frame requests while busy SHALL be ignored.
REQ-029 In the SAVE states SHALL hold:
  - override=1, force_write=1, memAddress=sp-1;
  - each state advances with sp<=sp-1;
  - frame_byte = pc_lat[7:0] (SAVE_LO), pc_lat[15:8] (SAVE_MID), {7'b0, pc_lat[16]} (SAVE_HI).
REQ-030 SAVE_LO -> SAVE_MID -> SAVE_HI -> IDLE, one state per unstalled cycle.
REQ-031 In the LOAD states SHALL hold:
  - override=1, force_write=0, memAddress=sp;
  - each state advances with sp<=sp+1.
REQ-032 The LOAD states SHALL capture read_data into ret_pc as follows:
  - LOAD_HI: read_data[0] into ret_pc[16];
  - LOAD_MID: read_data into ret_pc[15:8];
  - LOAD_LO: read_data into ret_pc[7:0].
REQ-033 LOAD_HI -> LOAD_MID -> LOAD_LO -> IDLE; ret_valid SHALL pulse in the cycle after LOAD_LO (IDLE).
REQ-034 A save SHALL occupy 3 cycles, and a return SHALL occupy 3 cycles plus the ret_valid cycle.
REQ-035 Instruction-driven pointer updates SHALL be suppressed while busy.
REQ-036 stall SHALL freeze state, pointers and pc_lat.
REQ-037 While stalled, outputs SHALL reflect the held state; ret_valid SHALL not repeat.

Reset
REQ-038 On reset: head=0x00, sp=0x00, state=IDLE, pc_lat=0, ret_pc=0, ret_valid=0, stk_err=0; override, force_write and frame_byte SHALL be 0.
REQ-039 Reset mid-save or mid-load SHALL abandon the frame, with no partial ret_valid.

Structure
REQ-040 The FSM state enum and the STACK_EMPTY=8'h00 constant SHALL live in package definitions, alongside op_code.
REQ-041 The pointer registers and arithmetic SHALL be one sub-module, ptr_regs; the FSM and output decode SHALL stay in mem_seq.

Verification
REQ-042 Reset, then MVR x3 -> head=0x03, and an INC shows memAddress=0x03.
REQ-043 PSH from sp=0x00 -> memAddress=0xFF, sp=0xFF; then POP -> memAddress=0xFF, sp=0x00, stk_err=0.
REQ-044 POP at sp=0x00 -> stk_err=1 and sp=0x01; stk_err stays 1 for 10 cycles until reset.
REQ-045 frame_save with pc=17'h1A5C3 -> writes C3@0xFF, A5@0xFE, 01@0xFD; busy is high 3 cycles; frame_ret then yields ret_pc=17'h1A5C3 with one ret_valid pulse.
REQ-046 frame_save and frame_ret asserted together, with stall pulsed during SAVE_MID -> save only, 4 busy cycles, sp=0xFD.
REQ-047 Reset asserted in LOAD_MID -> immediate IDLE, ret_valid never pulses, sp=0x00.

Source files
------------

// File: rtl/definitions.sv
// Shared types and constants for the memory sequencer.
//   op_code     : 9-bit instruction encoding seen on the Instruction port
//   state_t     : sequencer FSM states (idle, three save beats, three load beats)
//   ptr_op_t    : per-cycle command for a pointer register
//   STACK_EMPTY : stack pointer value meaning "nothing pushed"
package definitions;

  typedef enum logic [8:0] {
    NOP = 9'h000,
    INC = 9'h001,
    DEC = 9'h002,
    MVL = 9'h003,
    MVR = 9'h004,
    PSH = 9'h005,
    POP = 9'h006,
    OUT = 9'h007,
    INP = 9'h008
  } op_code;

  typedef enum logic [2:0] {
    IDLE,
    SAVE_LO,
    SAVE_MID,
    SAVE_HI,
    LOAD_HI,
    LOAD_MID,
    LOAD_LO
  } state_t;

  typedef enum logic [1:0] {
    PTR_HOLD,
    PTR_INC,
    PTR_DEC
  } ptr_op_t;

  localparam logic [7:0] STACK_EMPTY = 8'h00;

  // 8-bit pointer step; natural truncation gives modulo-256 wrap.
  function automatic logic [7:0] ptr_step(input logic [7:0] value, input ptr_op_t op);
    case (op)
      PTR_INC: ptr_step = value + 8'd1;
      PTR_DEC: ptr_step = value - 8'd1;
      default: ptr_step = value;
    endcase
  endfunction

endpackage

// File: rtl/ptr_regs.sv
// Data pointer (head) and stack pointer (sp) registers with wrap-around
// increment/decrement. The caller has already folded stall and busy
// gating into the op commands, so this block simply obeys them.
//   clk, reset : clock, async active-high reset (both pointers -> 0)
//   head_op    : hold / inc / dec command for head
//   sp_op      : hold / inc / dec command for sp
//   head, sp   : current pointer values
//   sp_dec     : sp - 1, the address of the next free stack slot
module ptr_regs
  import definitions::*;
(
  input  logic       clk,
  input  logic       reset,
  input  ptr_op_t    head_op,
  input  ptr_op_t    sp_op,
  output logic [7:0] head,
  output logic [7:0] sp,
  output logic [7:0] sp_dec
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head <= 8'h00;
      sp   <= STACK_EMPTY;
    end else begin
      head <= ptr_step(head, head_op);
      sp   <= ptr_step(sp, sp_op);
    end
  end

  assign sp_dec = ptr_step(sp, PTR_DEC);

endmodule

// File: rtl/mem_seq.sv
// Memory sequencer: decodes pointer instructions into a data-memory address
// and, on request, takes over the memory port to push or pop a 3-byte
// return frame holding a 17-bit program counter.
//   clk, reset  : clock, async active-high reset
//   Instruction : current instruction (op_code)
//   stall       : freezes FSM, pointers and pc_lat
//   pc          : program counter captured on a save request
//   frame_save  : request to push a return frame
//   frame_ret   : request to pop a return frame
//   read_data   : async memory read data for memAddress
//   memAddress  : memory address for this cycle
//   override    : sequencer owns the memory port
//   force_write : write strobe while override is high
//   frame_byte  : byte written during a save
//   busy        : FSM is not IDLE
//   ret_pc      : restored program counter
//   ret_valid   : one-cycle pulse once ret_pc is complete
//   stk_err     : sticky stack underflow flag
module mem_seq
  import definitions::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [8:0]  Instruction,
  input  logic        stall,
  input  logic [16:0] pc,
  input  logic        frame_save,
  input  logic        frame_ret,
  input  logic [7:0]  read_data,
  output logic [7:0]  memAddress,
  output logic        override,
  output logic        force_write,
  output logic [7:0]  frame_byte,
  output logic        busy,
  output logic [16:0] ret_pc,
  output logic        ret_valid,
  output logic        stk_err
);

  state_t      state, next_state;
  logic [16:0] pc_lat;
  logic [7:0]  head, sp, sp_dec;
  ptr_op_t     head_op, sp_op;
  op_code      op;
  logic        latch_pc, err_set;
  logic        cap_hi, cap_mid, cap_lo;

  assign op = op_code'(Instruction);

  ptr_regs u_ptr_regs (
    .clk     (clk),
    .reset   (reset),
    .head_op (head_op),
    .sp_op   (sp_op),
    .head    (head),
    .sp      (sp),
    .sp_dec  (sp_dec)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      pc_lat    <= 17'd0;
      ret_pc    <= 17'd0;
      ret_valid <= 1'b0;
      stk_err   <= 1'b0;
    end else begin
      state <= next_state;
      if (latch_pc) pc_lat <= pc;
      if (cap_hi)  ret_pc[16]   <= read_data[0];
      if (cap_mid) ret_pc[15:8] <= read_data;
      if (cap_lo)  ret_pc[7:0]  <= read_data;
      // Pulse once as LOAD_LO retires; a stall in the following IDLE cycle
      // cannot re-arm it because the state is no longer LOAD_LO.
      ret_valid <= (state == LOAD_LO) && !stall;
      if (err_set) stk_err <= 1'b1;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statements leaves one unassigned and no latch is inferred.
  always_comb begin
    next_state  = state;
    head_op     = PTR_HOLD;
    sp_op       = PTR_HOLD;
    memAddress  = head;
    override    = 1'b0;
    force_write = 1'b0;
    frame_byte  = 8'h00;
    latch_pc    = 1'b0;
    err_set     = 1'b0;
    cap_hi      = 1'b0;
    cap_mid     = 1'b0;
    cap_lo      = 1'b0;

    case (state)
      IDLE: begin
        case (op)
          PSH:     memAddress = sp_dec;
          POP:     memAddress = sp;
          default: memAddress = head;
        endcase
        if (!stall) begin
          if (frame_save) begin
            // Save wins over a simultaneous return; instruction is dropped.
            latch_pc   = 1'b1;
            next_state = SAVE_LO;
          end else if (frame_ret) begin
            next_state = LOAD_HI;
          end else begin
            case (op)
              PSH: sp_op = PTR_DEC;
              POP: begin
                sp_op   = PTR_INC;
                err_set = (sp == STACK_EMPTY);
              end
              MVL:     head_op = PTR_DEC;
              MVR:     head_op = PTR_INC;
              default: ;
            endcase
          end
        end
      end

      SAVE_LO, SAVE_MID, SAVE_HI: begin
        override    = 1'b1;
        force_write = 1'b1;
        memAddress  = sp_dec;
        case (state)
          SAVE_LO:  frame_byte = pc_lat[7:0];
          SAVE_MID: frame_byte = pc_lat[15:8];
          default:  frame_byte = {7'b0, pc_lat[16]};
        endcase
        if (!stall) begin
          sp_op = PTR_DEC;
          case (state)
            SAVE_LO:  next_state = SAVE_MID;
            SAVE_MID: next_state = SAVE_HI;
            default:  next_state = IDLE;
          endcase
        end
      end

      LOAD_HI, LOAD_MID, LOAD_LO: begin
        override   = 1'b1;
        memAddress = sp;
        if (!stall) begin
          sp_op   = PTR_INC;
          err_set = (sp == STACK_EMPTY);
          case (state)
            LOAD_HI: begin
              cap_hi     = 1'b1;
              next_state = LOAD_MID;
            end
            LOAD_MID: begin
              cap_mid    = 1'b1;
              next_state = LOAD_LO;
            end
            default: begin
              cap_lo     = 1'b1;
              next_state = IDLE;
            end
          endcase
        end
      end

      default: next_state = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_mem_seq.sv
// Directed bench for mem_seq with a scoreboard: frame writes and return
// pulses are queued as expected transactions and checked by a monitor.
module tb_mem_seq;
  import definitions::*;

  logic        clk;
  logic        reset;
  logic [8:0]  Instruction;
  logic        stall;
  logic [16:0] pc;
  logic        frame_save;
  logic        frame_ret;
  logic [7:0]  read_data;
  logic [7:0]  memAddress;
  logic        override;
  logic        force_write;
  logic [7:0]  frame_byte;
  logic        busy;
  logic [16:0] ret_pc;
  logic        ret_valid;
  logic        stk_err;

  mem_seq dut (
    .clk         (clk),
    .reset       (reset),
    .Instruction (Instruction),
    .stall       (stall),
    .pc          (pc),
    .frame_save  (frame_save),
    .frame_ret   (frame_ret),
    .read_data   (read_data),
    .memAddress  (memAddress),
    .override    (override),
    .force_write (force_write),
    .frame_byte  (frame_byte),
    .busy        (busy),
    .ret_pc      (ret_pc),
    .ret_valid   (ret_valid),
    .stk_err     (stk_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Simple data memory with asynchronous read.
  logic [7:0] mem [256];
  initial for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  always @(posedge clk) if (!reset && override && force_write && !stall) mem[memAddress] <= frame_byte;
  assign read_data = mem[memAddress];

  typedef struct {
    bit          is_ret;
    logic [7:0]  addr;
    logic [16:0] val;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   ret_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_write(input logic [7:0] a, input logic [7:0] d);
    exp_t e;
    e.is_ret = 1'b0; e.addr = a; e.val = {9'd0, d};
    q.push_back(e);
  endtask

  task automatic push_ret(input logic [16:0] v);
    exp_t e;
    e.is_ret = 1'b1; e.addr = 8'h00; e.val = v;
    q.push_back(e);
  endtask

  // Monitor: pops an expectation whenever the DUT presents a write or a return.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (override && force_write && !stall) begin
        check("sb_write_expected", q.size() != 0, 1'b1);
        if (q.size() != 0) begin
          e = q.pop_front();
          check("sb_kind_write", e.is_ret, 1'b0);
          check("sb_write_addr", memAddress, e.addr);
          check("sb_write_byte", frame_byte, e.val[7:0]);
        end
      end
      if (ret_valid) begin
        ret_count++;
        check("sb_ret_expected", q.size() != 0, 1'b1);
        if (q.size() != 0) begin
          e = q.pop_front();
          check("sb_kind_ret", e.is_ret, 1'b1);
          check("sb_ret_pc", ret_pc, e.val);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Read sp without changing it: a stalled POP drives memAddress = sp.
  task automatic peek_sp(input string name, input logic [7:0] exp);
    Instruction = POP;
    stall = 1'b1;
    #1;
    check(name, memAddress, exp);
    tick();
    stall = 1'b0;
    Instruction = NOP;
  endtask

  // Count busy cycles, optionally stalling on one of them; bounded.
  task automatic run_busy(input int stall_at, output int cnt);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (!busy) break;
      cnt++;
      stall = (i == stall_at);
      tick();
    end
    stall = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int cnt;
    int rc0;
    reset = 1'b1; stall = 1'b0; frame_save = 1'b0; frame_ret = 1'b0;
    pc = 17'd0; Instruction = NOP;
    tick();
    check("rst_memAddress", memAddress, 8'h00);
    check("rst_override", override, 1'b0);
    check("rst_force_write", force_write, 1'b0);
    check("rst_frame_byte", frame_byte, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_ret_pc", ret_pc, 17'h00000);
    check("rst_ret_valid", ret_valid, 1'b0);
    check("rst_stk_err", stk_err, 1'b0);
    reset = 1'b0;

    // Head pointer moves and wraps.
    Instruction = MVR;
    repeat (3) tick();
    Instruction = INC;
    #1 check("head_after_mvr3", memAddress, 8'h03);
    Instruction = MVL;
    repeat (4) tick();
    Instruction = NOP;
    #1 check("head_wrap_down", memAddress, 8'hFF);
    Instruction = MVR;
    tick();
    Instruction = NOP;
    #1 check("head_wrap_up", memAddress, 8'h00);
    peek_sp("sp_untouched_by_head", 8'h00);

    // Push then pop from empty.
    Instruction = PSH;
    #1 check("psh_addr", memAddress, 8'hFF);
    tick();
    peek_sp("sp_after_psh", 8'hFF);
    Instruction = POP;
    #1 check("pop_addr", memAddress, 8'hFF);
    tick();
    Instruction = NOP;
    peek_sp("sp_after_pop", 8'h00);
    check("no_err_after_pop", stk_err, 1'b0);

    // Underflow is sticky.
    Instruction = POP;
    #1 check("underflow_addr", memAddress, 8'h00);
    tick();
    Instruction = NOP;
    check("underflow_err", stk_err, 1'b1);
    peek_sp("sp_after_underflow", 8'h01);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("err_sticky", stk_err, 1'b1);
    end
    do_reset();
    check("err_cleared", stk_err, 1'b0);

    // Frame save and return of 17'h1A5C3.
    push_write(8'hFF, 8'hC3);
    push_write(8'hFE, 8'hA5);
    push_write(8'hFD, 8'h01);
    pc = 17'h1A5C3;
    frame_save = 1'b1;
    Instruction = MVR;
    tick();
    frame_save = 1'b0;
    run_busy(-1, cnt);
    check("save_busy_cycles", cnt, 3);
    Instruction = NOP;
    #1 check("head_suppressed", memAddress, 8'h00);
    peek_sp("sp_after_save", 8'hFD);
    push_ret(17'h1A5C3);
    rc0 = ret_count;
    frame_ret = 1'b1;
    tick();
    frame_ret = 1'b0;
    run_busy(-1, cnt);
    check("load_busy_cycles", cnt, 3);
    check("ret_valid_after_load", ret_valid, 1'b1);
    repeat (3) tick();
    check("ret_pulse_count", ret_count - rc0, 1);
    check("ret_pc_held", ret_pc, 17'h1A5C3);
    check("ret_valid_dropped", ret_valid, 1'b0);
    peek_sp("sp_after_load", 8'h00);

    // Simultaneous save/return with a stall in SAVE_MID.
    do_reset();
    push_write(8'hFF, 8'hEF);
    push_write(8'hFE, 8'hBE);
    push_write(8'hFD, 8'h00);
    rc0 = ret_count;
    pc = 17'h0BEEF;
    frame_save = 1'b1;
    frame_ret = 1'b1;
    tick();
    frame_save = 1'b0;
    frame_ret = 1'b0;
    run_busy(1, cnt);
    check("both_busy_cycles", cnt, 4);
    repeat (2) tick();
    check("both_no_ret", ret_count - rc0, 0);
    peek_sp("sp_after_both", 8'hFD);

    // Reset during LOAD_MID abandons the frame.
    rc0 = ret_count;
    frame_ret = 1'b1;
    tick();
    frame_ret = 1'b0;
    tick();
    check("in_load_mid_busy", busy, 1'b1);
    reset = 1'b1;
    #1;
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_override", override, 1'b0);
    check("async_rst_ret_valid", ret_valid, 1'b0);
    tick();
    reset = 1'b0;
    repeat (4) tick();
    check("abandon_no_ret", ret_count - rc0, 0);
    peek_sp("sp_after_abandon", 8'h00);

    repeat (2) tick();
    check("sb_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
